// File: rtl/fft_pkg.sv
// fft_pkg: shared magnitude width, peak-detector state type and saturating abs
package fft_pkg;
  localparam int MAG_EXTRA = 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
  function automatic int mag_width(input int w);
    return w + MAG_EXTRA;
  endfunction
  // |x| for a w-bit signed value held sign-extended in 32 bits; the most negative value clamps to max positive
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int w);
    if (x == -(32'sd1 <<< (w - 1))) return (32'd1 << (w - 1)) - 32'd1;
    return x[31] ? unsigned'(-x) : unsigned'(x);
  endfunction
endpackage

// File: rtl/fft_mag_approx.sv
// fft_mag_approx: 2-stage alpha-max-beta-min magnitude pipeline with valid and local index
module fft_mag_approx
  import fft_pkg::*;
#(
  parameter int W  = 16,
  parameter int SB = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic signed [W-1:0]         i_data_i,
  input  logic signed [W-1:0]         i_data_q,
  input  logic        [SB-1:0]        i_idx,
  output logic                        o_valid,
  output logic        [SB-1:0]        o_idx,
  output logic        [mag_width(W)-1:0] o_mag,
  output logic                        o_busy
);
  localparam int MW = mag_width(W);
  logic          v1;
  logic [SB-1:0] idx1;
  logic [W-1:0]  a, b, mx, mn;
  assign mx = a > b ? a : b;
  assign mn = a > b ? b : a;
  assign o_busy = v1 | o_valid;
  // stage 1: absolute values
  always_ff @(posedge i_clk) begin
    v1   <= i_reset ? 1'b0 : i_valid;
    idx1 <= i_idx;
    a    <= W'(sat_abs(32'(i_data_i), W));
    b    <= W'(sat_abs(32'(i_data_q), W));
  end
  // stage 2: max + min/2
  always_ff @(posedge i_clk) begin
    o_valid <= i_reset ? 1'b0 : v1;
    o_idx   <= idx1;
    o_mag   <= MW'(mx) + MW'(mn >> 1);
  end
endmodule

// File: rtl/fft_quarter_peak_detect.sv
// fft_quarter_peak_detect: per-quarter magnitude peak search with held valid/ready result
module fft_quarter_peak_detect
  import fft_pkg::*;
#(
  parameter int SIZE_BUFFER   = 4,
  parameter int DATA_FFT_SIZE = 16,
  parameter int QUARTER       = 0
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_valid,
  input  logic signed [DATA_FFT_SIZE-1:0]      i_data_i,
  input  logic signed [DATA_FFT_SIZE-1:0]      i_data_q,
  output logic                                 o_ready,
  output logic                                 o_peak_valid,
  output logic        [SIZE_BUFFER-1:0]        o_peak_index,
  output logic        [mag_width(DATA_FFT_SIZE)-1:0] o_peak_mag,
  input  logic                                 i_peak_ready
);
  localparam int SB = SIZE_BUFFER;
  localparam int NQ = 1 << (SB - 2);
  localparam logic [SB-1:0] OFFSET = SB'(QUARTER * NQ);
  localparam logic [SB-1:0] LAST   = SB'(NQ - 1);
  state_t                                state;
  logic [SB-1:0]                         count, m_idx;
  logic [mag_width(DATA_FFT_SIZE)-1:0]   m_mag;
  logic                                  m_valid, m_busy, take;
  assign take = i_valid & o_ready;
  fft_mag_approx #(.W(DATA_FFT_SIZE), .SB(SB)) u_mag (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (take),
    .i_data_i (i_data_i),
    .i_data_q (i_data_q),
    .i_idx    (count),
    .o_valid  (m_valid),
    .o_idx    (m_idx),
    .o_mag    (m_mag),
    .o_busy   (m_busy)
  );
  // frame sequencing: collect NQ bins, let the pipeline drain, then hold the result
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      count        <= '0;
      o_ready      <= 1'b1;
      o_peak_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: if (take) begin
          count   <= count + 1'b1;
          state   <= count == LAST ? DRAIN : ACCUM;
          o_ready <= count != LAST;
        end
        DRAIN: if (!m_busy) begin
          state        <= HOLD;
          o_peak_valid <= 1'b1;
        end
        HOLD: if (i_peak_ready) begin
          state        <= IDLE;
          count        <= '0;
          o_ready      <= 1'b1;
          o_peak_valid <= 1'b0;
        end
      endcase
    end
  end
  // first bin of a frame loads the peak; later bins only on strictly larger magnitude
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_peak_index <= '0;
      o_peak_mag   <= '0;
    end else if (m_valid && (m_idx == '0 || m_mag > o_peak_mag)) begin
      o_peak_index <= OFFSET + m_idx;
      o_peak_mag   <= m_mag;
    end
  end
endmodule

// File: tb/tb_fft_quarter_peak_detect.sv
// tb_fft_quarter_peak_detect: directed checks of the quarter peak detector
module tb_fft_quarter_peak_detect;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid = 1'b0;
  logic signed [15:0] di = '0, dq = '0;
  logic               pready = 1'b0;
  logic               rdy1, pv1, rdy3, pv3;
  logic [3:0]         idx1, idx3;
  logic [16:0]        mag1, mag3;
  int                 n = 0, bad = 0;

  always #5 clk = ~clk;

  fft_quarter_peak_detect #(.SIZE_BUFFER(4), .DATA_FFT_SIZE(16), .QUARTER(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data_i(di), .i_data_q(dq),
    .o_ready(rdy1), .o_peak_valid(pv1), .o_peak_index(idx1), .o_peak_mag(mag1),
    .i_peak_ready(pready)
  );
  fft_quarter_peak_detect #(.SIZE_BUFFER(4), .DATA_FFT_SIZE(16), .QUARTER(3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data_i(di), .i_data_q(dq),
    .o_ready(rdy3), .o_peak_valid(pv3), .o_peak_index(idx3), .o_peak_mag(mag3),
    .i_peak_ready(pready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int fi[4], input int fq[4]);
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1;
      di = 16'(fi[k]);
      dq = 16'(fq[k]);
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic wait_hold(input string tag);
    for (int k = 0; k < 20 && !pv1; k++) tick();
    chk(tag, 32'(pv1), 1);
  endtask

  task automatic pop(input string tag);
    pready = 1'b1;
    tick();
    pready = 1'b0;
    chk({tag, "_pv_clr"}, 32'(pv1), 0);
    chk({tag, "_rdy_set"}, 32'(rdy1), 1);
  endtask

  initial begin
    int seen;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(rdy1), 1);
    chk("rst_pv", 32'(pv1), 0);
    chk("rst_idx", 32'(idx1), 0);
    chk("rst_mag", 32'(mag1), 0);

    send_frame('{3, -10, 100, 5}, '{4, 0, -100, 5});
    chk("t1_ready_low", 32'(rdy1), 0);
    chk("t1_pv_t1", 32'(pv1), 0);
    tick();
    chk("t1_pv_t2", 32'(pv1), 0);
    tick();
    chk("t1_pv_t3", 32'(pv1), 0);
    tick();
    chk("t1_pv_t4", 32'(pv1), 1);
    chk("t1_idx", 32'(idx1), 6);
    chk("t1_mag", 32'(mag1), 150);
    pop("t1");

    send_frame('{7, 0, -7, 1}, '{0, 7, 0, 1});
    wait_hold("tie_hold");
    chk("tie_idx", 32'(idx1), 4);
    chk("tie_mag", 32'(mag1), 7);
    pop("tie");

    send_frame('{0, 0, -32768, 0}, '{0, 0, -32768, 0});
    wait_hold("ext_hold");
    chk("ext_idx", 32'(idx1), 6);
    chk("ext_mag", 32'(mag1), 49150);
    chk("ext_q3_idx", 32'(idx3), 14);
    chk("ext_q3_mag", 32'(mag3), 49150);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_ready", 32'(rdy1), 0);
      chk("bp_pv", 32'(pv1), 1);
      chk("bp_idx", 32'(idx1), 6);
      chk("bp_mag", 32'(mag1), 49150);
    end
    pop("bp");

    begin
      logic [6:0] pat = 7'b1011001;
      int gi[4] = '{3, -10, 100, 5};
      int gq[4] = '{4, 0, -100, 5};
      int b = 0;
      for (int k = 0; k < 7; k++) begin
        valid = pat[k];
        di = 16'(gi[b]);
        dq = 16'(gq[b]);
        tick();
        if (pat[k]) b++;
      end
      valid = 1'b1;
      di = 16'sd30000;
      dq = 16'sd30000;
      chk("gap_ready_low", 32'(rdy1), 0);
      wait_hold("gap_hold");
      chk("gap_ready_hold", 32'(rdy1), 0);
      chk("gap_idx", 32'(idx1), 6);
      chk("gap_mag", 32'(mag1), 150);
      valid = 1'b0;
      pop("gap");
    end

    valid = 1'b1;
    di = 16'sd50;
    dq = 16'sd0;
    tick();
    tick();
    valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", 32'(rdy1), 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (pv1) seen++;
      tick();
    end
    chk("mid_rst_no_pv", 32'(seen), 0);
    send_frame('{1, 1, 1, 1}, '{0, 0, 0, 0});
    wait_hold("post_rst_hold");
    chk("post_rst_idx", 32'(idx1), 4);
    chk("post_rst_mag", 32'(mag1), 1);
    pop("post_rst");

    $display("test done: total=%0d bad=%0d", n, bad);
    $finish;
  end
endmodule

// File: doc/fft_quarter_peak_detect.md
# fft_quarter_peak_detect

Downstream consumer of one quarter output of the four-way FFT interconnect. Accepts one quarter-frame (NFFT/4 complex bins) over a valid/ready handshake and computes an alpha-max-beta-min magnitude per bin. It tracks the largest magnitude and its absolute bin index, then presents one peak result per quarter-frame on a held valid/ready output. Four instances, one per quarter, sit behind the interconnect and feed the spectral-peak combiner.

## Interface
- SIZE_BUFFER, 4: log2(NFFT); must be ≥ 2; quarter-frame length is NFFT/4.
- DATA_FFT_SIZE, 16: width of signed two's-complement I and Q.
- QUARTER, 0: quarter number 0..3; sets the index offset QUARTER·NFFT/4.
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream bin valid (the interconnect's complete flag for this quarter).
- i_data_i  in  DATA_FFT_SIZE  signed real part.
- i_data_q  in  DATA_FFT_SIZE  signed imaginary part.
- o_ready  out  1  block can accept a bin (drives the interconnect's ready-to-receive flag).
- o_peak_valid  out  1  peak result available; held until accepted.
- o_peak_index  out  SIZE_BUFFER  absolute bin index of the peak.
- o_peak_mag  out  DATA_FFT_SIZE+1  unsigned approximate magnitude of the peak.
- i_peak_ready  in  1  downstream accepts the result.

## Operation
- Transfer: a bin is accepted on a rising edge where i_valid & o_ready. Otherwise inputs are ignored. Gaps in i_valid stall the frame, and the bin count is kept.
- Magnitude: a = |I|, b = |Q|. Abs of −2^(W−1) saturates to 2^(W−1)−1. mag = max(a,b) + (min(a,b) >> 1), computed in W+1 bits unsigned, with no overflow possible.
- Peak: the first bin of a frame loads the peak unconditionally. Later bins replace the peak only if mag > peak_mag (strictly greater), so on a tie the earliest index wins.
- Index: QUARTER·(NFFT/4) + local bin count (0..NFFT/4−1), SIZE_BUFFER bits.
- FSM:
  - IDLE: o_ready=1. The first accepted bin moves to ACCUM, count=1.
  - ACCUM: o_ready=1. Count increments per accepted bin. When bin NFFT/4 is accepted, go to DRAIN.
  - DRAIN: o_ready=0. Waits for the 2-stage magnitude pipeline to empty, then goes to HOLD.
  - HOLD: o_peak_valid=1 and o_ready=0. On i_peak_ready, go to IDLE and clear count.
- Reset: FSM to IDLE, count=0, pipeline valids=0, o_peak_valid=0, o_peak_index=0, o_peak_mag=0. o_ready is 1 from the first cycle after reset.
- Reset mid-frame or in HOLD discards the partial or pending result. No result is emitted.

## Timing
- Magnitude pipeline latency is 2 edges: stage 1 computes abs, stage 2 computes max/min and the sum. The peak register updates on the 3rd edge after acceptance.
- Last bin accepted at edge T: o_ready is 0 after edge T. o_peak_valid is 1 after edge T+3.
- Result fields are stable while o_peak_valid=1 & !i_peak_ready.
- i_peak_ready with o_peak_valid at edge H: o_peak_valid=0 and o_ready=1 after edge H. The next frame's first bin can be accepted at edge H+1.
- Minimum frame period is NFFT/4 + 4 cycles with i_peak_ready tied high.
- i_peak_ready outside HOLD is ignored.

## Structure
- Shared package fft_pkg holds:
  - magnitude width (DATA_FFT_SIZE+1);
  - the FSM state typedef {IDLE, ACCUM, DRAIN, HOLD};
  - the saturating-abs function.
- Sub-module fft_mag_approx: 2-stage I/Q → magnitude pipeline carrying a valid bit and local index. The top level holds the FSM, counter and peak registers.

## Test plan
All cases use SIZE_BUFFER=4 (4 bins per frame), W=16, QUARTER=1, unless stated otherwise.
- Bins (3,4), (−10,0), (100,−100), (5,5) → mags 5, 10, 150, 7. Expect o_peak_index=6, o_peak_mag=150, o_peak_valid exactly 3 edges after the last accept.
- Tie: (7,0), (0,7), (−7,0), (1,1) → index 4, mag 7.
- Extremes: (−32768,−32768) in bin 2, others (0,0) → index 6, mag 49150. Repeat with QUARTER=3 → index 14.
- Backpressure: i_peak_ready low for 5 cycles in HOLD → o_ready=0 and result fields unchanged throughout. Raising i_peak_ready gives o_ready=1 next cycle.
- Gapped input: i_valid pattern 1,0,0,1,1,0,1 → exactly 4 bins accepted and the result matches the ungapped run. With i_valid held high, the 5th bin is not accepted (o_ready=0).
- Reset asserted after bin 2 → no o_peak_valid. The following full frame (1,0)×4 → index 4, mag 1.
